mult: RTL and testbench

Sequential 32×32 multiplier for the MIPS core's MULT/MULTU path; the companion to the iterative divider. It accepts two 32-bit operands and a signed/unsigned select. It produces the 64-bit product as `hi`/`lo` using a radix-2 shift-add datapath, and signals completion with `done`. The HI/LO register file writeback and the pipeline stall logic consume `hi`, `lo`, `busy` and `done`.

---
 rtl/mult.sv | 128 ++++++++++++
 tb/tb_mult.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mult.sv
// ----------------------------------------------------------------------------
// mult -- sequential 32x32 multiplier for the MULT/MULTU path.
//
// Radix-2 shift-add datapath over operand magnitudes, followed by a single
// two's-complement sign correction step. The result is written to hi/lo only
// at the SIGN step, so the outputs never show partial sums.
//
// Ports:
//   clk       in   1   rising-edge clock
//   multrst   in   1   synchronous, active-high reset (wins over start)
//   start     in   1   request, accepted in IDLE or DONE
//   signmult  in   1   1 = signed (MULT), 0 = unsigned (MULTU)
//   a         in  32   multiplicand, sampled with start
//   b         in  32   multiplier, sampled with start
//   hi        out 32   product bits [63:32]
//   lo        out 32   product bits [31:0]
//   busy      out  1   operation in progress (RUN/SIGN)
//   done      out  1   result valid and held
//
// Configuration:
//   MULT_EARLY_TERM_EN  when defined, RUN ends as soon as the remaining
//                       multiplier bits are all zero (minimum one RUN cycle).
//                       Undefined: always 32 RUN cycles, 33-cycle latency.
// ----------------------------------------------------------------------------
module mult (
  input  logic        clk,
  input  logic        multrst,
  input  logic        start,
  input  logic        signmult,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state;
  logic [63:0] mcand;   // multiplicand, shifted left each RUN cycle
  logic [31:0] mplier;  // multiplier, shifted right each RUN cycle
  logic [63:0] acc;     // unsigned product of the magnitudes
  logic [4:0]  count;   // RUN cycles completed
  logic        neg;     // final product must be negated

  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [63:0] acc_next;
  logic [31:0] mplier_shift;
  logic        last_run;

  // Magnitudes wrap for 0x80000000, which is exactly the unsigned value
  // 2^31 we want to multiply.
  assign abs_a        = (signmult && a[31]) ? (32'd0 - a) : a;
  assign abs_b        = (signmult && b[31]) ? (32'd0 - b) : b;
  assign acc_next     = mplier[0] ? (acc + mcand) : acc;
  assign mplier_shift = mplier >> 1;

`ifdef MULT_EARLY_TERM_EN
  // No set bits left means every further add would be zero.
  assign last_run = (mplier_shift == 32'd0) || (count == 5'd31);
`else
  assign last_run = (count == 5'd31);
`endif

  // NOTE: all state here is sequential and uses non-blocking assignments so
  // every register sees the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (multrst) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
      neg    <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            mcand  <= {32'd0, abs_a};
            mplier <= abs_b;
            neg    <= signmult & (a[31] ^ b[31]);
            acc    <= '0;
            count  <= '0;
            state  <= RUN;
            busy   <= 1'b1;
            done   <= 1'b0;
          end
        end

        RUN: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier_shift;
          count  <= count + 5'd1;
          if (last_run) begin
            state <= SIGN;
          end
        end

        SIGN: begin
          // Negating zero yields zero, so a zero operand needs no special case.
          {hi, lo} <= neg ? (64'd0 - acc) : acc;
          state    <= DONE;
          busy     <= 1'b0;
          done     <= 1'b1;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult.sv
// ----------------------------------------------------------------------------
// tb_mult -- directed self-checking bench for mult.
//
// Drives inputs on the falling edge and samples outputs 1 time unit after the
// rising edge. Expected products are hand-computed constants; expected
// latency follows the MULT_EARLY_TERM_EN setting of the build.
// ----------------------------------------------------------------------------
module tb_mult;

  logic        clk = 1'b0;
  logic        multrst;
  logic        start;
  logic        signmult;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int start_cyc;
  int lat;

  mult dut (
    .clk      (clk),
    .multrst  (multrst),
    .start    (start),
    .signmult (signmult),
    .a        (a),
    .b        (b),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected cycles from the start edge to the edge after which done is seen.
  function automatic int exp_lat(input logic sg, input logic [31:0] bb);
`ifdef MULT_EARLY_TERM_EN
    logic [31:0] m;
    int n;
    m = (sg && bb[31]) ? (32'd0 - bb) : bb;
    n = 1;
    for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
    return n + 1;
`else
    return 33;
`endif
  endfunction

  // Present a request for one edge, then scramble operands to show they are
  // not re-sampled while busy.
  task automatic launch(input logic sg, input logic [31:0] aa, input logic [31:0] bb);
    @(negedge clk);
    start    = 1'b1;
    signmult = sg;
    a        = aa;
    b        = bb;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    start     = 1'b0;
    a         = 32'hDEAD_BEEF;
    b         = 32'h0BAD_F00D;
    signmult  = ~sg;
  endtask

  // Wait (bounded) for done; also checks busy stayed high until then.
  task automatic wait_done(input string tag, output int latency);
    bit dropped;
    dropped = 1'b0;
    latency = -1;
    for (int k = 0; k < 100; k++) begin
      if (done) begin
        latency = cyc - start_cyc;
        break;
      end
      if (!busy) dropped = 1'b1;
      @(posedge clk);
      #1;
    end
    check({tag, " done_reached"}, {63'd0, done}, 64'd1);
    check({tag, " busy_until_done"}, {63'd0, dropped}, 64'd0);
  endtask

  task automatic run_op(input string tag, input logic sg, input logic [31:0] aa,
                        input logic [31:0] bb, input logic [31:0] ehi, input logic [31:0] elo);
    int l;
    launch(sg, aa, bb);
    check({tag, " busy_after_start"}, {63'd0, busy}, 64'd1);
    wait_done(tag, l);
    check({tag, " latency"}, 64'(l), 64'(exp_lat(sg, bb)));
    check({tag, " busy_in_done"}, {63'd0, busy}, 64'd0);
    check({tag, " hi"}, {32'd0, hi}, {32'd0, ehi});
    check({tag, " lo"}, {32'd0, lo}, {32'd0, elo});
  endtask

  initial begin
    multrst  = 1'b1;
    start    = 1'b0;
    signmult = 1'b0;
    a        = '0;
    b        = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset hi", {32'd0, hi}, 64'd0);
    check("reset lo", {32'd0, lo}, 64'd0);
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset done", {63'd0, done}, 64'd0);
    @(negedge clk);
    multrst = 1'b0;

    run_op("u9x2", 1'b0, 32'h0000_0009, 32'h0000_0002, 32'h0000_0000, 32'h0000_0012);
    // Result and done hold in DONE while no new start arrives.
    repeat (3) @(posedge clk);
    #1;
    check("hold done", {63'd0, done}, 64'd1);
    check("hold lo", {32'd0, lo}, 64'h12);

    run_op("s-3x5", 1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("u-3x5", 1'b0, 32'hFFFF_FFFD, 32'h0000_0005, 32'h0000_0004, 32'hFFFF_FFF1);
    run_op("s_min2", 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run_op("u_max2", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("s0xneg", 1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000);
    run_op("s_negx0", 1'b1, 32'hFFFF_FFF0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000);

    // start while busy is ignored.
    launch(1'b1, 32'd7, 32'd6);
    repeat (9) @(posedge clk);
    @(negedge clk);
    start    = 1'b1;
    signmult = 1'b0;
    a        = 32'd5;
    b        = 32'h0000_00FF;
    @(posedge clk);
    #1;
    start = 1'b0;
`ifndef MULT_EARLY_TERM_EN
    check("ignore busy_mid", {63'd0, busy}, 64'd1);
`endif
    wait_done("ignore", lat);
    check("ignore latency", 64'(lat), 64'(exp_lat(1'b1, 32'd6)));
    check("ignore hi", {32'd0, hi}, 64'd0);
    check("ignore lo", {32'd0, lo}, 64'h2A);

    // start in DONE is accepted and done drops at that edge.
    launch(1'b0, 32'd3, 32'd4);
    check("restart done_low", {63'd0, done}, 64'd0);
    check("restart busy", {63'd0, busy}, 64'd1);
    wait_done("restart", lat);
    check("restart lo", {32'd0, lo}, 64'd12);

    // Reset mid-RUN, with start also high: reset wins.
    launch(1'b1, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (13) @(posedge clk);
    @(negedge clk);
    multrst = 1'b1;
    start   = 1'b1;
    @(posedge clk);
    #1;
    check("rst busy", {63'd0, busy}, 64'd0);
    check("rst done", {63'd0, done}, 64'd0);
    check("rst hi", {32'd0, hi}, 64'd0);
    check("rst lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    multrst = 1'b0;
    start   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst idle busy", {63'd0, busy}, 64'd0);
    check("rst idle done", {63'd0, done}, 64'd0);

    run_op("post_rst 3x3", 1'b1, 32'd3, 32'd3, 32'd0, 32'd9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
